// File: rtl/cam_pkg.sv
// Shared types and constants for the camera stream emulator.
package cam_pkg;

  typedef enum logic [2:0] {IDLE, VSYNC, VBACK, ACTIVE, VFRONT} state_e;

  typedef enum logic [1:0] {
    PAT_BARS    = 2'd0,
    PAT_RAMP    = 2'd1,
    PAT_FRAMEID = 2'd2,
    PAT_CHECK   = 2'd3
  } pat_e;

  localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
  localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
  localparam logic [15:0] BAR_CYAN    = 16'h07FF;
  localparam logic [15:0] BAR_GREEN   = 16'h07E0;
  localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
  localparam logic [15:0] BAR_RED     = 16'hF800;
  localparam logic [15:0] BAR_BLUE    = 16'h001F;
  localparam logic [15:0] BAR_BLACK   = 16'h0000;

  function automatic logic [15:0] bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    return BAR_WHITE;
      3'd1:    return BAR_YELLOW;
      3'd2:    return BAR_CYAN;
      3'd3:    return BAR_GREEN;
      3'd4:    return BAR_MAGENTA;
      3'd5:    return BAR_RED;
      3'd6:    return BAR_BLUE;
      default: return BAR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/cam_pattern_lut.sv
// Maps pixel coordinates and the latched pattern code to one RGB565 word.
module cam_pattern_lut
  import cam_pkg::*;
(
  input  pat_e        pat,
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  input  logic [2:0]  bar_idx,
  input  logic [7:0]  frame_cnt,
  output logic [15:0] w
);

  always_comb begin
    w = 16'h0000;
    case (pat)
      PAT_BARS:    w = bar_color(bar_idx);
      PAT_RAMP:    w = {x, y};
      PAT_FRAMEID: w = {8'hA5, frame_cnt};
      PAT_CHECK:   w = (x[3] ^ y[3]) ? 16'hFFFF : 16'h0000;
      default:     w = 16'h0000;
    endcase
  end

endmodule

// File: rtl/cam_stream_gen.sv
// OV7670-style sensor emulator: vsync/href timing and RGB565 bytes, high byte first.
// Outputs are registered from the next-state values so they line up with state changes.
module cam_stream_gen
  import cam_pkg::*;
#(
  parameter int H_PIX       = 160,
  parameter int V_PIX       = 120,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10
) (
  input  logic       pclk,
  input  logic       reset,
  input  logic       enable,
  input  logic [1:0] pattern_sel,
  output logic       vsync,
  output logic       href,
  output logic [7:0] dout,
  output logic       frame_done,
  output logic [7:0] frame_cnt,
  output logic       busy
);

  localparam int LINE_LEN  = 2 * H_PIX + H_BLANK;
  localparam int HW        = $clog2(LINE_LEN);
  localparam int VW        = $clog2(VSYNC_LINES + V_BACK + V_PIX + V_FRONT + 1);
  localparam int BAR_BYTES = H_PIX / 4;
  localparam int BW        = $clog2(BAR_BYTES);
  localparam logic [HW-1:0] H_LAST   = HW'(LINE_LEN - 1);
  localparam logic [HW-1:0] H_ACT    = HW'(2 * H_PIX);
  localparam logic [BW-1:0] BAR_LAST = BW'(BAR_BYTES - 1);

  state_e        state_q, state_d;
  pat_e          pat_q, pat_d;
  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d, v_last;
  logic [BW-1:0] bar_byte_q, bar_byte_d;
  logic [2:0]    bar_idx_q, bar_idx_d;
  logic [7:0]    frame_cnt_q, frame_cnt_d, dout_q, dout_d;
  logic          vsync_q, vsync_d, href_q, href_d;
  logic          frame_done_q, frame_done_d, busy_q, busy_d;
  logic          line_end, state_end;
  logic [HW-1:0] x_pix;
  logic [7:0]    x8, y8;
  logic [15:0]   word;

  assign x_pix = h_cnt_d >> 1;
  assign x8    = 8'(x_pix);
  assign y8    = 8'(v_cnt_d);

  cam_pattern_lut u_lut (
    .pat       (pat_d),
    .x         (x8),
    .y         (y8),
    .bar_idx   (bar_idx_d),
    .frame_cnt (frame_cnt_q),
    .w         (word)
  );

  always_comb begin
    state_d     = state_q;
    pat_d       = pat_q;
    h_cnt_d     = h_cnt_q;
    v_cnt_d     = v_cnt_q;
    bar_byte_d  = bar_byte_q;
    bar_idx_d   = bar_idx_q;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      VSYNC:   v_last = VW'(VSYNC_LINES - 1);
      VBACK:   v_last = VW'(V_BACK - 1);
      ACTIVE:  v_last = VW'(V_PIX - 1);
      VFRONT:  v_last = VW'(V_FRONT - 1);
      default: v_last = '0;
    endcase
    line_end  = (h_cnt_q == H_LAST);
    state_end = line_end && (v_cnt_q == v_last);

    if (state_q == IDLE) begin
      if (enable) begin
        state_d = VSYNC;
        pat_d   = pat_e'(pattern_sel);
        h_cnt_d = '0;
        v_cnt_d = '0;
      end
    end else begin
      h_cnt_d = line_end ? '0 : h_cnt_q + HW'(1);
      v_cnt_d = line_end ? v_cnt_q + VW'(1) : v_cnt_q;
      if (state_end) begin
        v_cnt_d = '0;
        case (state_q)
          VSYNC:  state_d = VBACK;
          VBACK:  state_d = ACTIVE;
          ACTIVE: state_d = VFRONT;
          VFRONT: begin
            // Only place enable is sampled once running: frames are never cut short.
            if (enable) begin
              state_d = VSYNC;
              pat_d   = pat_e'(pattern_sel);
            end else begin
              state_d = IDLE;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end

    href_d       = (state_d == ACTIVE) && (h_cnt_d < H_ACT);
    vsync_d      = (state_d == VSYNC);
    busy_d       = (state_d != IDLE);
    frame_done_d = (state_d == VFRONT) && (h_cnt_d == H_LAST) &&
                   (v_cnt_d == VW'(V_FRONT - 1));
    frame_cnt_d  = frame_cnt_q + 8'(frame_done_d);

    // Bar position tracks the byte shown next cycle; a counter avoids dividing x.
    if (h_cnt_d == '0) begin
      bar_byte_d = '0;
      bar_idx_d  = '0;
    end else if (href_d) begin
      if (bar_byte_q == BAR_LAST) begin
        bar_byte_d = '0;
        bar_idx_d  = bar_idx_q + 3'd1;
      end else begin
        bar_byte_d = bar_byte_q + BW'(1);
      end
    end

    dout_d = href_d ? (h_cnt_d[0] ? word[7:0] : word[15:8]) : 8'h00;
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      pat_q        <= PAT_BARS;
      h_cnt_q      <= '0;
      v_cnt_q      <= '0;
      bar_byte_q   <= '0;
      bar_idx_q    <= '0;
      frame_cnt_q  <= '0;
      dout_q       <= '0;
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      frame_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pat_q        <= pat_d;
      h_cnt_q      <= h_cnt_d;
      v_cnt_q      <= v_cnt_d;
      bar_byte_q   <= bar_byte_d;
      bar_idx_q    <= bar_idx_d;
      frame_cnt_q  <= frame_cnt_d;
      dout_q       <= dout_d;
      vsync_q      <= vsync_d;
      href_q       <= href_d;
      frame_done_q <= frame_done_d;
      busy_q       <= busy_d;
    end
  end

  assign vsync      = vsync_q;
  assign href       = href_q;
  assign dout       = dout_q;
  assign frame_done = frame_done_q;
  assign frame_cnt  = frame_cnt_q;
  assign busy       = busy_q;

endmodule
